// File: rtl/fetch_unit.sv
// Instruction fetch stage: reads the two 16-bit words at {pointer0, pointer1}
// and presents them as one 32-bit instruction until retire loads a new pointer pair.

module fetch_word_lane #(
  parameter int WORD_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [WORD_W-1:0] d,
  output logic [WORD_W-1:0] q
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       q <= '0;
    else if (load) q <= d;
  end
endmodule

module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] next_pointer,
  input  logic        retire,
  output logic [31:0] instr_pointer,
  output logic [31:0] instruction,
  output logic        instr_valid,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata
);
  localparam int NUM_WORDS = 2;
  localparam int WORD_W    = 16;

  // Fetch states are numbered so that state value i fetches word lane i.
  typedef enum logic [1:0] {F0 = 2'd0, F1 = 2'd1, READY = 2'd2} fetch_state_e;

  fetch_state_e state, state_nxt;

  // Packed with pointer0 / word@pointer0 in the upper half.
  logic [NUM_WORDS-1:0][WORD_W-1:0] ptr_q;
  logic [NUM_WORDS-1:0][WORD_W-1:0] word_q;
  logic [NUM_WORDS-1:0]             lane_sel;
  logic [NUM_WORDS-1:0]             lane_load;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= F0;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      F0:      if (mem_ack) state_nxt = F1;
      F1:      if (mem_ack) state_nxt = READY;
      READY:   if (retire)  state_nxt = F0;
      default:              state_nxt = F0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          ptr_q <= {RESET_PC, RESET_PC + 16'd1};
    else if (state == READY && retire) ptr_q <= next_pointer;
  end

  for (genvar i = 0; i < NUM_WORDS; i++) begin : g_lane
    assign lane_sel[i]  = (state == fetch_state_e'(2'(i)));
    assign lane_load[i] = lane_sel[i] & mem_ack;

    fetch_word_lane #(.WORD_W(WORD_W)) u_lane (
      .clk  (clk),
      .rst  (rst),
      .load (lane_load[i]),
      .d    (mem_rdata),
      .q    (word_q[NUM_WORDS-1-i])
    );
  end

  // Address is a pure decode of the state register; zero outside fetch.
  always_comb begin
    mem_addr = '0;
    for (int i = 0; i < NUM_WORDS; i++)
      if (lane_sel[i]) mem_addr = ptr_q[NUM_WORDS-1-i];
  end

  assign mem_req       = |lane_sel;
  assign instr_valid   = (state == READY);
  assign instr_pointer = ptr_q;
  assign instruction   = word_q;
endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: memory responder with configurable wait states
// and a reference model giving the expected instruction, addresses and latency.

module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] next_pointer = '0;
  logic        retire = 1'b0;
  logic [31:0] instr_pointer;
  logic [31:0] instruction;
  logic        instr_valid;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_rdata = '0;

  int errs = 0;
  int checks = 0;

  logic [15:0] mem [0:65535];
  logic [15:0] addr_q[$];
  int          waits = 0;

  fetch_unit #(.RESET_PC(16'h0000)) dut (
    .clk           (clk),
    .rst           (rst),
    .next_pointer  (next_pointer),
    .retire        (retire),
    .instr_pointer (instr_pointer),
    .instruction   (instruction),
    .instr_valid   (instr_valid),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_ack       (mem_ack),
    .mem_rdata     (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Memory responder: acks after `waits` idle cycles, logs every completed address.
  initial begin
    int          cnt;
    logic [15:0] held;
    cnt = 0;
    held = '0;
    forever begin
      @(negedge clk);
      if (rst || !mem_req) begin
        mem_ack = 1'b0;
        cnt = 0;
      end else begin
        if (cnt == 0) held = mem_addr;
        else          chk("addr_hold", {16'h0, mem_addr}, {16'h0, held});
        if (cnt >= waits) begin
          mem_ack   = 1'b1;
          mem_rdata = mem[mem_addr];
          addr_q.push_back(mem_addr);
          cnt = 0;
        end else begin
          mem_ack = 1'b0;
          cnt++;
        end
      end
    end
  end

  // Counts rising edges until instr_valid is seen; bounded.
  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!instr_valid && n < 60);
  endtask

  task automatic check_fetch(input string tag, input logic [31:0] ptr, input int w);
    int n;
    wait_valid(n);
    chk({tag, "_lat"}, n, 2 + 2 * w);
    chk({tag, "_valid"}, {31'h0, instr_valid}, 32'h1);
    chk({tag, "_ptr"}, instr_pointer, ptr);
    chk({tag, "_instr"}, instruction, {mem[ptr[31:16]], mem[ptr[15:0]]});
    chk({tag, "_nreq"}, addr_q.size(), 2);
    if (addr_q.size() >= 2) begin
      chk({tag, "_a0"}, {16'h0, addr_q[0]}, {16'h0, ptr[31:16]});
      chk({tag, "_a1"}, {16'h0, addr_q[1]}, {16'h0, ptr[15:0]});
    end
    chk({tag, "_rdy_req"}, {31'h0, mem_req}, 32'h0);
    chk({tag, "_rdy_addr"}, {16'h0, mem_addr}, 32'h0);
  endtask

  // Called at posedge+1 in READY: retire on the next edge, then release.
  task automatic do_retire(input string tag, input logic [31:0] np);
    addr_q.delete();
    next_pointer = np;
    retire = 1'b1;
    @(posedge clk);
    #1;
    retire = 1'b0;
    next_pointer = $urandom;
    chk({tag, "_drop"}, {31'h0, instr_valid}, 32'h0);
    chk({tag, "_newptr"}, instr_pointer, np);
  endtask

  task automatic wait_addr(input logic [15:0] a);
    int n;
    n = 0;
    while (mem_addr !== a && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("reach_addr", {16'h0, mem_addr}, {16'h0, a});
  endtask

  initial begin
    logic [31:0] p;
    int          w;

    for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
    mem[0] = 16'h1234;
    mem[1] = 16'hABCD;

    // Asynchronous reset before any clock edge.
    #1 rst = 1'b1;
    #2;
    chk("rst_ptr", instr_pointer, 32'h0000_0001);
    chk("rst_instr", instruction, 32'h0);
    chk("rst_valid", {31'h0, instr_valid}, 32'h0);
    chk("rst_req", {31'h0, mem_req}, 32'h1);
    chk("rst_addr", {16'h0, mem_addr}, 32'h0);
    @(posedge clk);
    #2 rst = 1'b0;
    addr_q.delete();
    check_fetch("boot", 32'h0000_0001, 0);
    chk("boot_word", instruction, 32'h1234ABCD);

    // Branch retire.
    do_retire("br", 32'h0040_0041);
    check_fetch("br", 32'h0040_0041, 0);

    // Wait states: three idle cycles per word.
    waits = 3;
    p = {16'($urandom), 16'($urandom)};
    do_retire("ws", p);
    check_fetch("ws", p, 3);

    // Retire held during F1 is ignored.
    waits = 2;
    p = 32'h1111_2222;
    do_retire("ig", p);
    wait_addr(16'h2222);
    retire = 1'b1;
    next_pointer = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    retire = 1'b0;
    chk("ig_ptr", instr_pointer, p);
    chk("ig_req", {31'h0, mem_req}, 32'h1);
    chk("ig_addr", {16'h0, mem_addr}, 32'h2222);
    begin
      int n;
      wait_valid(n);
      chk("ig_ptr2", instr_pointer, p);
      chk("ig_instr", instruction, {mem[16'h1111], mem[16'h2222]});
    end

    // Wrap pointers.
    waits = 0;
    do_retire("wr", 32'hFFFF_0000);
    check_fetch("wr", 32'hFFFF_0000, 0);

    // Random back-to-back instructions, retire on the first valid cycle.
    for (int k = 0; k < 24; k++) begin
      w = $urandom_range(0, 3);
      waits = w;
      p = {16'($urandom), 16'($urandom)};
      do_retire("rnd", p);
      check_fetch("rnd", p, w);
    end

    // Reset asserted between edges while in F1.
    waits = 1;
    do_retire("mr", 32'h0040_0041);
    wait_addr(16'h0041);
    #1 rst = 1'b1;
    #1;
    chk("mr_ptr", instr_pointer, 32'h0000_0001);
    chk("mr_req", {31'h0, mem_req}, 32'h1);
    chk("mr_addr", {16'h0, mem_addr}, 32'h0);
    chk("mr_valid", {31'h0, instr_valid}, 32'h0);
    chk("mr_instr", instruction, 32'h0);
    @(posedge clk);
    #2 rst = 1'b0;
    waits = 0;
    addr_q.delete();
    check_fetch("mr", 32'h0000_0001, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage feeding the next-pointer counter. It holds the architectural instruction pointer pair `{pointer0, pointer1}` and reads the two 16-bit words at those addresses from instruction memory over a req/ack handshake. It presents them as one 32-bit instruction (`{word@pointer0, word@pointer1}`) to decode and execute. On retire it loads the counter's `_next_pointer` as the new pointer pair and starts the next fetch.

## Interface

- `RESET_PC`, 16'h0000, address of the first instruction word after reset.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `next_pointer` input 32: `{pointer0, pointer1}` from the counter; sampled only on retire.
- `retire` input 1: the current instruction is complete and `next_pointer` is valid this cycle.
- `instr_pointer` output 32: current `{pointer0, pointer1}`; drives the counter's instr_pointer.
- `instruction` output 32: `{mem[pointer0], mem[pointer1]}`; meaningful only while `instr_valid=1`.
- `instr_valid` output 1: `instruction` and `instr_pointer` are stable and consumable.
- `mem_req` output 1: memory read request.
- `mem_addr` output 16: memory word address.
- `mem_ack` input 1: read completes this cycle; `mem_rdata` is valid.
- `mem_rdata` input 16: read data.

## Operation

- FSM states: F0 (fetch the word at pointer0), F1 (fetch the word at pointer1), READY.
- Reset values:
  - state = F0.
  - `instr_pointer = {RESET_PC, RESET_PC+1}`; the +1 is 16-bit and wraps.
  - `instruction = 0`, `instr_valid = 0`.
- Outputs decoded from the state register only, never from inputs:
  - `mem_req` = 1 in F0 and F1.
  - `mem_addr` = `instr_pointer[31:16]` in F0 and `instr_pointer[15:0]` in F1.
  - `mem_addr` = 0 in READY.
  - `instr_valid` = 1 in READY.
- A transfer completes in any cycle with `mem_req=1` and `mem_ack=1`. `mem_ack` is ignored while `mem_req=0`.
- F0: on ack, `instruction[31:16] <= mem_rdata` and go to F1. Without ack, stay in F0 with the address held stable.
- F1: on ack, `instruction[15:0] <= mem_rdata` and go to READY. Without ack, stay in F1.
- READY: hold all outputs.
  - On `retire=1`: `instr_pointer <= next_pointer`, go to F0, and `instr_valid` drops at that edge.
- `retire` in F0 or F1 is ignored: no pointer update and no state change.
- Both words are always fetched. The decision whether the second word is an immediate is made downstream.
- Pointer values are used exactly as given. The block performs no address arithmetic except the reset-time `RESET_PC+1`.
- `instruction` bits may change during F0/F1. Consumers must qualify them with `instr_valid`.
- Asynchronous reset mid-fetch:
  - State returns immediately to F0.
  - `mem_req` stays asserted, because it is decoded from state F0, with `mem_addr = RESET_PC`.
  - A pending ack from the aborted access is not distinguishable. The memory must also be reset by `rst`.

## Timing

- Zero-wait memory (ack in the same cycle as req): `retire` sampled at edge t, then F0 during cycle t..t+1, F1 during t+1..t+2, and `instr_valid=1` from edge t+2.
- Minimum retire-to-valid latency is 2 cycles. Each wait-state cycle adds 1.
- First fetch after reset release: `mem_req=1` with `mem_addr=RESET_PC` is visible from the first cycle after `rst` falls. With zero wait, `instr_valid` rises at the 2nd rising edge after reset release.
- `retire` in READY can be asserted on the first valid cycle, giving a single-cycle instruction.
- Maximum throughput is one instruction per 3 cycles: 2 fetch cycles plus 1 READY cycle.
- `instr_pointer` changes only at a retire edge or on reset. It is constant for the whole F0/F1/READY sequence.

## Test plan

- Reset checks:
  - With `rst` asserted and `RESET_PC=0`: `instr_pointer=0x00000001`, `instruction=0`, `instr_valid=0`, `mem_req=1`, `mem_addr=0x0000`.
  - Assert `rst` asynchronously between edges: outputs take these values before the next edge.
- Zero-wait fetch: mem[0]=0x1234, mem[1]=0xABCD. Addresses issued are 0x0000 then 0x0001, `instruction=0x1234ABCD`, and `instr_valid` rises 2 edges after reset release.
- Wait states: ack delayed 3 cycles per word. `mem_addr` is held stable throughout each wait, and `instr_valid` rises after 8 cycles.
- Retire/branch: in READY, pulse `retire` with `next_pointer=0x00400041`. Then `instr_pointer=0x00400041`, `instr_valid` drops on that edge, addresses issued are 0x0040 then 0x0041, and `instr_valid` returns 2 cycles later.
- Ignored retire and wrap:
  - Assert `retire` during F1 with garbage `next_pointer`: no effect.
  - Then retire with `0xFFFF0000`: addresses issued are 0xFFFF then 0x0000, and the instruction is assembled correctly.
- Reset mid-operation: assert `rst` while in F1 with `next_pointer` loaded to 0x0040. The FSM restarts at F0 with `mem_addr=RESET_PC`, and `instr_valid` stays 0 until the new fetch completes.
